// File: rtl/a23_io_pkg.sv
// Shared definitions for the a23 character output port: register map, STATUS and CTRL layout.
package a23_io_pkg;

  localparam logic [31:0] IO_BASE_ADR = 32'h1000_0000;

  // Register index taken from address bits [3:2]
  typedef enum logic [1:0] {
    IO_DATA   = 2'd0,
    IO_STATUS = 2'd1,
    IO_CTRL   = 2'd2,
    IO_RSVD   = 2'd3
  } io_reg_e;

  localparam int unsigned STATUS_EMPTY     = 0;
  localparam int unsigned STATUS_FULL      = 1;
  localparam int unsigned STATUS_EOF       = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  localparam int unsigned CTRL_CLR_EOF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

  // Pack the STATUS register word
  function automatic logic [31:0] io_status_word(logic [7:0] count, logic eof, logic full,
                                                 logic empty);
    logic [31:0] word;
    word                             = '0;
    word[STATUS_COUNT_LSB +: 8]      = count;
    word[STATUS_EOF]                 = eof;
    word[STATUS_FULL]                = full;
    word[STATUS_EMPTY]               = empty;
    return word;
  endfunction

endpackage

// File: rtl/a23_wb_io_port_if.sv
// Wishbone slave bus plus the byte-stream consumer side of the character output port.
interface a23_wb_io_port_if;
  logic [31:0] i_wb_adr;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [31:0] o_wb_dat;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic        o_out_valid;
  logic [7:0]  o_out_data;
  logic        i_out_ready;
  logic        o_eof;

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb, i_out_ready,
    output o_wb_dat, o_wb_ack, o_wb_err, o_out_valid, o_out_data, o_eof
  );

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb, i_out_ready,
    input  o_wb_dat, o_wb_ack, o_wb_err, o_out_valid, o_out_data, o_eof
  );
endinterface

// File: rtl/a23_sync_fifo.sv
// Synchronous FIFO with flush and a registered head word (o_head is valid whenever !o_empty).
module a23_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign o_full     = (count_q == (AW+1)'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign do_pop     = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a full FIFO needs
  assign do_push    = i_push & (~o_full | do_pop);
  assign rd_ptr_inc = rd_ptr_q + AW'(1);

  // Next head: the pushed word lands straight in the head register when it becomes the oldest entry
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count_q == (AW+1)'(1)) head_d = i_wdata;
      else                       head_d = mem_q[rd_ptr_inc];
    end else if (do_push && o_empty) begin
      head_d = i_wdata;
    end
  end

  // Pointer, occupancy and head update; flush overrides any pop
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      head_q   <= head_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_count = count_q;
  assign o_head  = head_q;

endmodule

// File: rtl/a23_wb_io_port.sv
// Wishbone slave for the character output port: register decode, wait states, eof flag, read mux.
module a23_wb_io_port
  import a23_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = IO_BASE_ADR,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  a23_wb_io_port_if.slave bus
);

  logic              ack_q, err_q, eof_q;
  logic [31:0]       dat_q;
  io_reg_e           offset;
  logic              in_window, req, data_wr, data_zero, push_req, stall, push, pop;
  logic              set_eof, ctrl_wr, clr_eof, flush, bad_acc, rd_status;
  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_count;
  logic [7:0]        fifo_head;
  logic [31:0]       status_word;
  logic              unused_ok;

  assign unused_ok = ^{bus.i_wb_adr[1:0], bus.i_wb_sel[3:1]};

  // Decode of the current request; ack_q blocks a second request on the ack cycle
  always_comb begin
    offset      = io_reg_e'(bus.i_wb_adr[3:2]);
    in_window   = (bus.i_wb_adr[31:4] == BASE_ADR[31:4]);
    req         = bus.i_wb_cyc & bus.i_wb_stb & ~ack_q;
    data_zero   = (bus.i_wb_dat == '0);
    data_wr     = req & bus.i_wb_we & in_window & (offset == IO_DATA) & bus.i_wb_sel[0];
    push_req    = data_wr & ~data_zero;
    pop         = ~fifo_empty & bus.i_out_ready;
    stall       = push_req & fifo_full & ~pop;
    push        = push_req & ~stall;
    set_eof     = data_wr & data_zero;
    ctrl_wr     = req & bus.i_wb_we & in_window & (offset == IO_CTRL);
    clr_eof     = ctrl_wr & bus.i_wb_dat[CTRL_CLR_EOF];
    flush       = ctrl_wr & bus.i_wb_dat[CTRL_FLUSH];
    // Anything outside the window is treated like the reserved slot rather than left hanging
    bad_acc     = req & (~in_window | (offset == IO_RSVD));
    rd_status   = req & ~bus.i_wb_we & in_window & (offset == IO_STATUS);
    status_word = io_status_word(8'(fifo_count), eof_q, fifo_full, fifo_empty);
  end

  // Registered bus response and sticky end-of-output flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      eof_q <= 1'b0;
    end else begin
      ack_q <= req & ~stall;
      err_q <= bad_acc;
      dat_q <= rd_status ? status_word : '0;
      if (set_eof)      eof_q <= 1'b1;
      else if (clr_eof) eof_q <= 1'b0;
    end
  end

  a23_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (bus.i_wb_dat[7:0]),
    .i_pop   (pop),
    .i_flush (flush),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count),
    .o_head  (fifo_head)
  );

  assign bus.o_wb_ack    = ack_q;
  assign bus.o_wb_err    = err_q;
  assign bus.o_wb_dat    = dat_q;
  assign bus.o_eof       = eof_q;
  assign bus.o_out_valid = ~fifo_empty;
  assign bus.o_out_data  = fifo_head;

endmodule

// File: tb/tb_a23_wb_io_port.sv
// Bench for the character output port: queue-based model checked every cycle plus directed tests.
module tb_a23_wb_io_port;

  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA   = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_CTRL   = 32'h1000_0008;
  localparam logic [31:0] A_RSVD   = 32'h1000_000C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  a23_wb_io_port_if bus ();

  a23_wb_io_port #(
    .BASE_ADR   (32'h1000_0000),
    .FIFO_DEPTH (DEPTH),
    .FIFO_AW    (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  bit          m_eof, m_ack, m_err;
  logic [31:0] m_dat;

  always @(posedge clk) begin : model
    bit          pop, req, push, flush, n_ack, n_err;
    logic [31:0] n_dat, st;
    if (rst) begin
      mq.delete();
      m_eof = 0; m_ack = 0; m_err = 0; m_dat = '0;
    end else begin
      pop   = (mq.size() != 0) && bus.i_out_ready;
      req   = bus.i_wb_cyc && bus.i_wb_stb && !m_ack;
      push  = 0; flush = 0; n_ack = 0; n_err = 0; n_dat = '0;
      st    = {16'h0, 8'(mq.size()), 5'h0, m_eof, mq.size() == DEPTH, mq.size() == 0};
      if (req) begin
        case (bus.i_wb_adr[3:2])
          2'd0: begin
            if (bus.i_wb_we && bus.i_wb_sel[0] && bus.i_wb_dat != 0) begin
              if (mq.size() < DEPTH || pop) begin push = 1; n_ack = 1; end
            end else begin
              if (bus.i_wb_we && bus.i_wb_sel[0]) m_eof = 1;
              n_ack = 1;
            end
          end
          2'd1: begin n_ack = 1; if (!bus.i_wb_we) n_dat = st; end
          2'd2: begin
            n_ack = 1;
            if (bus.i_wb_we) begin
              if (bus.i_wb_dat[0]) m_eof = 0;
              flush = bus.i_wb_dat[1];
            end
          end
          default: begin n_ack = 1; n_err = 1; end
        endcase
      end
      if (flush) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(bus.i_wb_dat[7:0]);
      end
      m_ack = n_ack; m_err = n_err; m_dat = n_dat;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ack", 32'(bus.o_wb_ack), 32'(m_ack));
    chk("err", 32'(bus.o_wb_err), 32'(m_err));
    chk("out_valid", 32'(bus.o_out_valid), 32'(mq.size() != 0));
    chk("eof", 32'(bus.o_eof), 32'(m_eof));
    if (mq.size() != 0) chk("out_data", 32'(bus.o_out_data), 32'(mq[0]));
    if (m_ack) chk("rdata", bus.o_wb_dat, m_dat);
  end

  // ---------------- bus helpers ----------------
  logic [31:0] rdv;
  bit          errv;
  int          waits;
  logic [7:0]  drained[$];

  task automatic wb(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd, output bit err,
                    output int nwait);
    bit got;
    @(negedge clk);
    if (bus.o_wb_ack) @(negedge clk);  // let the previous ack retire
    bus.i_wb_adr = adr; bus.i_wb_we = we; bus.i_wb_dat = dat; bus.i_wb_sel = sel;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    nwait = 0; rd = '0; err = 0; got = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (bus.o_wb_ack) begin got = 1; rd = bus.o_wb_dat; err = bus.o_wb_err; break; end
      nwait++;
    end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_timeout: got no ack expected ack for adr %h", adr);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    wb(adr, 1'b1, dat, 4'hF, rdv, errv, waits);
  endtask

  task automatic rd_status();
    wb(A_STATUS, 1'b0, '0, 4'hF, rdv, errv, waits);
  endtask

  task automatic drain();
    drained.delete();
    @(negedge clk);
    bus.i_out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!bus.o_out_valid) break;
      drained.push_back(bus.o_out_data);
      @(negedge clk);
    end
    bus.i_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_wb_adr = '0; bus.i_wb_sel = '0; bus.i_wb_we = 1'b0; bus.i_wb_dat = '0;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset state, single-cycle latency
    chk("t1_valid", 32'(bus.o_out_valid), 32'h0);
    chk("t1_eof", 32'(bus.o_eof), 32'h0);
    rd_status();
    chk("t1_status", rdv, 32'h0000_0001);
    chk("t1_waits", 32'(waits), 32'h0);

    // 2: three bytes held, byte-lane-0 disabled write ignored, then drained in order
    wr(A_DATA, 32'h41); wr(A_DATA, 32'h42); wr(A_DATA, 32'h43);
    wb(A_DATA, 1'b1, 32'h5A, 4'b0010, rdv, errv, waits);
    rd_status();
    chk("t2_status", rdv, 32'h0000_0300);
    drain();
    chk("t2_n", 32'(drained.size()), 32'd3);
    if (drained.size() == 3) begin
      chk("t2_b0", 32'(drained[0]), 32'h41);
      chk("t2_b1", 32'(drained[1]), 32'h42);
      chk("t2_b2", 32'(drained[2]), 32'h43);
    end

    // 3: full FIFO stalls a push until a pop frees a slot
    for (int i = 1; i <= DEPTH; i++) wr(A_DATA, 32'(i));
    rd_status();
    chk("t3_status_full", rdv, 32'h0000_1002);
    fork
      wr(A_DATA, 32'h55);
      begin
        wait (bus.i_wb_stb);
        repeat (5) @(negedge clk);
        bus.i_out_ready = 1'b1;
        @(negedge clk);
        bus.i_out_ready = 1'b0;
      end
    join
    chk("t3_waits", 32'(waits), 32'd5);
    drain();
    chk("t3_n", 32'(drained.size()), 32'd16);
    if (drained.size() == 16) begin
      chk("t3_first", 32'(drained[0]), 32'h02);
      chk("t3_last", 32'(drained[15]), 32'h55);
    end

    // 4: eof set/hold/clear and flush
    for (int i = 0; i < 4; i++) wr(A_DATA, 32'h61 + 32'(i));
    wr(A_DATA, 32'h0);
    chk("t4_eof_set", 32'(bus.o_eof), 32'h1);
    rd_status();
    chk("t4_status_eof", rdv, 32'h0000_0404);
    wr(A_DATA, 32'h0);
    rd_status();
    chk("t4_status_eof2", rdv, 32'h0000_0404);
    wr(A_CTRL, 32'h1);
    rd_status();
    chk("t4_status_clr", rdv, 32'h0000_0400);
    wr(A_CTRL, 32'h2);
    chk("t4_valid", 32'(bus.o_out_valid), 32'h0);
    rd_status();
    chk("t4_status_flush", rdv, 32'h0000_0001);

    // 5: reserved offset errors with no side effect
    wr(A_RSVD, 32'h1234);
    chk("t5_err_w", 32'(errv), 32'h1);
    wb(A_RSVD, 1'b0, '0, 4'hF, rdv, errv, waits);
    chk("t5_err_r", 32'(errv), 32'h1);
    rd_status();
    chk("t5_status", rdv, 32'h0000_0001);
    chk("t5_err_status", 32'(errv), 32'h0);

    // zero write while full needs no wait state
    for (int i = 1; i <= DEPTH; i++) wr(A_DATA, 32'h80 + 32'(i));
    wr(A_DATA, 32'h0);
    chk("t5_zero_full_waits", 32'(waits), 32'h0);
    rd_status();
    chk("t5_status_full_eof", rdv, 32'h0000_1006);

    // 6: reset during a stalled write
    @(negedge clk);
    bus.i_wb_adr = A_DATA; bus.i_wb_we = 1'b1; bus.i_wb_dat = 32'h77; bus.i_wb_sel = 4'hF;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    @(posedge clk); #1;
    chk("t6_ack", 32'(bus.o_wb_ack), 32'h0);
    chk("t6_eof", 32'(bus.o_eof), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_status();
    chk("t6_status", rdv, 32'h0000_0001);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
